// File: rtl/spi_master_ctrl.sv
// Byte-oriented SPI mode-0 master sequencer driven by an external half-bit tick generator.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting on MOSI and MISO.
module spi_master_ctrl #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CS_SETUP_TICKS = 1,
  parameter int unsigned CS_HOLD_TICKS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              tick_en,
  input  logic              tick,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] BitLast   = CntW'(DATA_W - 1);
  localparam logic [3:0]      SetupLast = 4'(CS_SETUP_TICKS - 1);
  localparam logic [3:0]      HoldLast  = 4'(CS_HOLD_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StGap, StHold} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic              last_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [3:0]        tick_cnt_q;

  logic              accept;
  logic              first_bit;
  logic              next_bit;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_shifted;

  assign accept = cmd_valid & cmd_ready;

`ifdef SPI_LSB_FIRST_EN
  assign first_bit  = cmd_data[0];
  assign next_bit   = tx_sr_q[1];
  assign tx_shifted = tx_sr_q >> 1;
  assign rx_shifted = {spi_miso, rx_sr_q[DATA_W-1:1]};
`else
  assign first_bit  = cmd_data[DATA_W-1];
  assign next_bit   = tx_sr_q[DATA_W-2];
  assign tx_shifted = tx_sr_q << 1;
  assign rx_shifted = {rx_sr_q[DATA_W-2:0], spi_miso};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_ready  <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      busy       <= 1'b0;
      tick_en    <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      last_q     <= 1'b0;
      bit_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tx_sr_q    <= cmd_data;
            last_q     <= cmd_last;
            spi_mosi   <= first_bit;
            spi_cs_n   <= 1'b0;
            tick_en    <= 1'b1;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            tick_cnt_q <= '0;
            state_q    <= StSetup;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        StSetup: begin
          if (tick) begin
            if (tick_cnt_q == SetupLast) begin
              bit_cnt_q <= '0;
              spi_sclk  <= 1'b0;
              state_q   <= StXfer;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        StXfer: begin
          if (tick) begin
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
              rx_sr_q <= rx_shifted;
            end else if (bit_cnt_q == BitLast) begin
              // Word done: generator is cleared here; HOLD re-enables it from a fresh count.
              rx_data    <= rx_sr_q;
              rx_valid   <= 1'b1;
              tick_en    <= 1'b0;
              tick_cnt_q <= '0;
              if (last_q) begin
                state_q <= StHold;
              end else begin
                cmd_ready <= 1'b1;
                state_q   <= StGap;
              end
            end else begin
              tx_sr_q   <= tx_shifted;
              spi_mosi  <= next_bit;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
        end
        StGap: begin
          if (accept) begin
            tx_sr_q   <= cmd_data;
            last_q    <= cmd_last;
            spi_mosi  <= first_bit;
            tick_en   <= 1'b1;
            cmd_ready <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= StXfer;
          end
        end
        StHold: begin
          if (tick && (tick_cnt_q == HoldLast)) begin
            spi_cs_n  <= 1'b1;
            tick_en   <= 1'b0;
            spi_mosi  <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end else begin
            tick_en <= 1'b1;
            if (tick) begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl with a 4-clk tick generator model.
// Bit-order expectations follow SPI_LSB_FIRST_EN when it is defined for the build.
module tb_spi_master_ctrl;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_last = 1'b0;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          busy;
  logic          tick_en;
  logic          tick = 1'b0;
  logic          spi_cs_n;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_miso;
  logic          loop_en = 1'b1;
  logic          miso_force = 1'b0;
  logic [3:0]    tcnt = 4'd0;

  int tests = 0;
  int fails = 0;

  spi_master_ctrl #(.DATA_W(DW), .CS_SETUP_TICKS(1), .CS_HOLD_TICKS(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .cmd_last (cmd_last),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .tick_en  (tick_en),
    .tick     (tick),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  assign spi_miso = loop_en ? spi_mosi : miso_force;

  // Tick model: first pulse 2 clk after tick_en rises, then every 4 clk.
  always @(posedge clk) begin
    if (!tick_en) begin
      tcnt <= 4'd0;
      tick <= 1'b0;
    end else begin
      tcnt <= tcnt + 4'd1;
      tick <= (tcnt[1:0] == 2'd1);
    end
  end

  // Passive monitor; counters only grow, tests compare differences.
  int          rise_cnt = 0;
  int          rxv_cnt = 0;
  int          rxv_double = 0;
  int          cs_rise_cnt = 0;
  int          cs_tick_cnt = 0;
  int          acc_cnt = 0;
  int          mosi_hi_cnt = 0;
  logic [31:0] mosi_bits = '0;
  logic [31:0] rx_log = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_rxv = 1'b0;

  always @(negedge clk) begin
    if (spi_sclk && !prev_sclk) begin
      rise_cnt  <= rise_cnt + 1;
      mosi_bits <= {mosi_bits[30:0], spi_mosi};
    end
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_log  <= {rx_log[23:0], rx_data};
    end
    if (rx_valid && prev_rxv) rxv_double <= rxv_double + 1;
    if (spi_cs_n && !prev_cs) cs_rise_cnt <= cs_rise_cnt + 1;
    if (tick && !spi_cs_n) cs_tick_cnt <= cs_tick_cnt + 1;
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    if (!spi_cs_n && spi_mosi) mosi_hi_cnt <= mosi_hi_cnt + 1;
    prev_sclk <= spi_sclk;
    prev_cs   <= spi_cs_n;
    prev_rxv  <= rx_valid;
  end

  task automatic send_word(input logic [DW-1:0] data, input logic last, output bit ok);
    cmd_data  = data;
    cmd_last  = last;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({cmd_ready, rx_valid, busy, tick_en, spi_cs_n, spi_sclk, spi_mosi} !== 7'b0000100) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0000100",
               {cmd_ready, rx_valid, busy, tick_en, spi_cs_n, spi_sclk, spi_mosi});
    end
    tests++;
    if (rx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rx_data got %h want 00", rx_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_single;
    bit ok;
    int r0, v0, c0;
    r0 = rise_cnt; v0 = rxv_cnt; c0 = cs_tick_cnt;
    loop_en = 1'b1;
    send_word(8'hA5, 1'b1, ok);
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_done got busy want idle");
    end
    tests++;
    if (rise_cnt - r0 !== 8) begin
      fails++;
      $display("FAIL single_rises got %0d want 8", rise_cnt - r0);
    end
    tests++;
    if (mosi_bits[7:0] !== 8'hA5) begin
      fails++;
      $display("FAIL single_mosi got %h want a5", mosi_bits[7:0]);
    end
    tests++;
    if (rxv_cnt - v0 !== 1 || rx_log[7:0] !== 8'hA5) begin
      fails++;
      $display("FAIL single_rx got %0d x %h want 1 x a5", rxv_cnt - v0, rx_log[7:0]);
    end
    tests++;
    if (cs_tick_cnt - c0 !== 18) begin
      fails++;
      $display("FAIL single_cs_ticks got %0d want 18", cs_tick_cnt - c0);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int r0, v0, c0, s0;
    r0 = rise_cnt; v0 = rxv_cnt; c0 = cs_tick_cnt; s0 = cs_rise_cnt;
    send_word(8'h3C, 1'b0, ok);
    send_word(8'hC3, 1'b1, ok);
    wait_idle(ok);
    tests++;
    if (cs_rise_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL burst_cs_rises got %0d want 1", cs_rise_cnt - s0);
    end
    tests++;
    if (rxv_cnt - v0 !== 2 || rx_log[15:0] !== 16'h3CC3) begin
      fails++;
      $display("FAIL burst_rx got %0d x %h want 2 x 3cc3", rxv_cnt - v0, rx_log[15:0]);
    end
    tests++;
    if (rise_cnt - r0 !== 16 || mosi_bits[15:0] !== 16'h3CC3) begin
      fails++;
      $display("FAIL burst_sclk got %0d x %h want 16 x 3cc3", rise_cnt - r0, mosi_bits[15:0]);
    end
    tests++;
    if (cs_tick_cnt - c0 !== 34) begin
      fails++;
      $display("FAIL burst_cs_ticks got %0d want 34", cs_tick_cnt - c0);
    end
  endtask

  task automatic test_miso_ones;
    bit ok;
    int m0;
    m0 = mosi_hi_cnt;
    loop_en = 1'b0;
    miso_force = 1'b1;
    send_word(8'h00, 1'b1, ok);
    wait_idle(ok);
    loop_en = 1'b1;
    tests++;
    if (rx_data !== 8'hFF) begin
      fails++;
      $display("FAIL ones_rx got %h want ff", rx_data);
    end
    tests++;
    if (mosi_hi_cnt - m0 !== 0) begin
      fails++;
      $display("FAIL ones_mosi got %0d high cycles want 0", mosi_hi_cnt - m0);
    end
  endtask

  task automatic test_hold_valid;
    bit ok;
    int r0, v0, a0;
    r0 = rise_cnt; v0 = rxv_cnt; a0 = acc_cnt;
    send_word(8'h5A, 1'b0, ok);
    cmd_data  = 8'h96;
    cmd_last  = 1'b1;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    tests++;
    if (!ok || rise_cnt - r0 !== 8 || rxv_cnt - v0 !== 1) begin
      fails++;
      $display("FAIL hold_gate got ok=%0d rises=%0d rxv=%0d want 1 8 1",
               ok, rise_cnt - r0, rxv_cnt - v0);
    end
    wait_idle(ok);
    tests++;
    if (acc_cnt - a0 !== 2) begin
      fails++;
      $display("FAIL hold_accepts got %0d want 2", acc_cnt - a0);
    end
    tests++;
    if (rx_log[15:0] !== 16'h5A96) begin
      fails++;
      $display("FAIL hold_rx got %h want 5a96", rx_log[15:0]);
    end
  endtask

  task automatic test_bit_order;
    bit ok;
    logic [7:0] exp_mosi;
`ifdef SPI_LSB_FIRST_EN
    exp_mosi = 8'h80;
`else
    exp_mosi = 8'h01;
`endif
    send_word(8'h01, 1'b1, ok);
    wait_idle(ok);
    tests++;
    if (mosi_bits[7:0] !== exp_mosi) begin
      fails++;
      $display("FAIL order_mosi got %h want %h", mosi_bits[7:0], exp_mosi);
    end
    tests++;
    if (rx_data !== 8'h01) begin
      fails++;
      $display("FAIL order_rx got %h want 01", rx_data);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    int r0, v0;
    r0 = rise_cnt;
    cmd_data  = 8'hFF;
    cmd_last  = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (rise_cnt - r0 >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    v0 = rxv_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (!ok || {spi_cs_n, spi_sclk, tick_en, busy, rx_valid} !== 5'b10000) begin
      fails++;
      $display("FAIL midrst_outputs got ok=%0d %b want 1 10000",
               ok, {spi_cs_n, spi_sclk, tick_en, busy, rx_valid});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_ready got %b want 1", cmd_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rxv_cnt - v0 !== 0) begin
      fails++;
      $display("FAIL midrst_rxv got %0d want 0", rxv_cnt - v0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_miso_ones();
    test_hold_valid();
    test_bit_order();
    test_mid_reset();
    tests++;
    if (rxv_double !== 0) begin
      fails++;
      $display("FAIL rxv_width got %0d long strobes want 0", rxv_double);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
